irl_pio_mux: RTL

Parametrised PIO slave-side decoder and response sequencer for NUM_CH memory channels on the block-register bus. It decodes a select field of `reg_addr`, drives one channel-select strobe per channel and waits for that channel's ack on the `clk_div` tick grid. It then returns a registered ack/rvalid/rdata response, with an error response for unmapped addresses and non-responding channels. It is the generic replacement for per-block two-channel PIO muxes and adds timeout and error accounting.

---
 rtl/irl_pio_mux.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/irl_pio_mux.sv
// PIO slave-side channel decoder and response sequencer for NUM_CH memory channels.
// One access at a time; strobes arriving while busy are dropped; responses move only on clk_div ticks.
module irl_pio_mux #(
   parameter int NUM_CH    = 4,
   parameter int PIO_NBITS = 32,
   parameter int SEL_LSB   = 8,
   parameter int SEL_NBITS = 4,
   parameter logic [NUM_CH*SEL_NBITS-1:0] CH_CODE = {4'd3, 4'd2, 4'd1, 4'd0},
   parameter int TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clk_div,
   input  logic                        reg_bs,
   input  logic                        reg_wr,
   input  logic                        reg_rd,
   input  logic [PIO_NBITS-1:0]        reg_addr,
   input  logic [NUM_CH-1:0]           ch_ack,
   input  logic [NUM_CH*PIO_NBITS-1:0] ch_rdata,
   input  logic                        err_clr,
   output logic [NUM_CH-1:0]           reg_ms,
   output logic                        pio_ack,
   output logic                        pio_rvalid,
   output logic [PIO_NBITS-1:0]        pio_rdata,
   output logic                        pio_err,
   output logic [7:0]                  err_cnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t               state, state_nx;
   logic                 is_rd, is_rd_nx;
   logic                 miss, miss_nx;
   logic [IDX_W-1:0]     idx, idx_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic                 ack_nx, rvalid_nx, err_nx;
   logic [PIO_NBITS-1:0] rdata_nx;
   logic [7:0]           err_cnt_nx;
   logic                 err_inc;

   logic [SEL_NBITS-1:0] sel;
   logic                 hit_any;
   logic [IDX_W-1:0]     hit_idx;
   logic                 sel_ack;
   logic [PIO_NBITS-1:0] sel_rdata;
   logic                 start;
   logic                 unused_addr;

   assign sel         = reg_addr[SEL_LSB +: SEL_NBITS];
   assign start       = reg_bs & (reg_rd | reg_wr);
   assign unused_addr = ^reg_addr;

   // Scan from the top so that duplicate codes resolve to the lowest channel.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      reg_ms  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (sel == CH_CODE[i*SEL_NBITS +: SEL_NBITS]) begin
            hit_any   = 1'b1;
            hit_idx   = IDX_W'(i);
            reg_ms    = '0;
            reg_ms[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_ack   = ch_ack[i];
            sel_rdata = ch_rdata[i*PIO_NBITS +: PIO_NBITS];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      is_rd_nx  = is_rd;
      miss_nx   = miss;
      idx_nx    = idx;
      cnt_nx    = cnt;
      ack_nx    = pio_ack;
      rvalid_nx = pio_rvalid;
      rdata_nx  = pio_rdata;
      err_nx    = pio_err;
      err_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               is_rd_nx = reg_rd;
               idx_nx   = hit_idx;
               miss_nx  = ~hit_any;
               cnt_nx   = '0;
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (clk_div) begin
               if (miss || (!sel_ack && cnt == CNT_W'(TIMEOUT - 1))) begin
                  state_nx  = ST_RESP;
                  ack_nx    = 1'b1;
                  err_nx    = 1'b1;
                  rvalid_nx = 1'b0;
                  rdata_nx  = '0;
                  err_inc   = 1'b1;
               end else if (sel_ack) begin
                  state_nx  = ST_RESP;
                  ack_nx    = 1'b1;
                  err_nx    = 1'b0;
                  rvalid_nx = is_rd;
                  rdata_nx  = is_rd ? sel_rdata : '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         ST_RESP: begin
            if (clk_div) begin
               state_nx  = ST_IDLE;
               ack_nx    = 1'b0;
               err_nx    = 1'b0;
               rvalid_nx = 1'b0;
               rdata_nx  = '0;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      // A clear coinciding with an increment still leaves zero.
      err_cnt_nx = err_cnt;
      if (err_clr)
         err_cnt_nx = 8'd0;
      else if (err_inc && err_cnt != 8'hFF)
         err_cnt_nx = err_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         is_rd      <= 1'b0;
         miss       <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
         pio_ack    <= 1'b0;
         pio_rvalid <= 1'b0;
         pio_rdata  <= '0;
         pio_err    <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         state      <= state_nx;
         is_rd      <= is_rd_nx;
         miss       <= miss_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         pio_ack    <= ack_nx;
         pio_rvalid <= rvalid_nx;
         pio_rdata  <= rdata_nx;
         pio_err    <= err_nx;
         err_cnt    <= err_cnt_nx;
      end
   end

endmodule
